// File: rtl/issue_scoreboard_pkg.sv
// Shared constants and the per-line request bundle for the issue scoreboard.
package issue_scoreboard_pkg;

    localparam int SB_REG_NUM = 32;
    localparam int SB_REG_AW  = 5;

    localparam logic WRITE_ENABLE = 1'b1;

    // One launch line's register usage, as seen by the hazard checker.
    typedef struct packed {
        logic                 re1;
        logic [SB_REG_AW-1:0] raddr1;
        logic                 re2;
        logic [SB_REG_AW-1:0] raddr2;
        logic                 we;
        logic [SB_REG_AW-1:0] waddr;
        logic                 long_op;
    } line_req_t;

    localparam int LINE_REQ_W = $bits(line_req_t);

endpackage

// File: rtl/issue_hazard_chk.sv
// Combinational RAW/WAW hazard check of one line against the effective pending bits.
module issue_hazard_chk
    import issue_scoreboard_pkg::*;
#(
    parameter int REG_NUM = SB_REG_NUM
) (
    input  line_req_t          req,
    input  logic [REG_NUM-1:0] pend_eff,
    output logic               block
);

    logic raw1;
    logic raw2;
    logic waw;

    // A source read or a nonzero destination that is still in flight blocks the line.
    always_comb begin
        raw1  = req.re1 & pend_eff[req.raddr1];
        raw2  = req.re2 & pend_eff[req.raddr2];
        waw   = (req.we == WRITE_ENABLE) & (req.waddr != '0) & pend_eff[req.waddr];
        block = raw1 | raw2 | waw;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-line issue controller: pending bits for long-latency writes, issue grants,
// in-pair dependency checks and a stall performance counter.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int REG_NUM = SB_REG_NUM,
    parameter int REG_AW  = SB_REG_AW,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               excep_flush_i,
    input  logic               next_allowin_i,
    input  logic               l1_valid_i,
    input  logic               l1_re1_i,
    input  logic               l1_re2_i,
    input  logic [REG_AW-1:0]  l1_raddr1_i,
    input  logic [REG_AW-1:0]  l1_raddr2_i,
    input  logic               l1_we_i,
    input  logic [REG_AW-1:0]  l1_waddr_i,
    input  logic               l1_long_i,
    input  logic               l1_jmp_i,
    input  logic               l2_valid_i,
    input  logic               l2_re1_i,
    input  logic               l2_re2_i,
    input  logic [REG_AW-1:0]  l2_raddr1_i,
    input  logic [REG_AW-1:0]  l2_raddr2_i,
    input  logic               l2_we_i,
    input  logic [REG_AW-1:0]  l2_waddr_i,
    input  logic               l2_long_i,
    input  logic               wb1_we_i,
    input  logic [REG_AW-1:0]  wb1_waddr_i,
    input  logic               wb2_we_i,
    input  logic [REG_AW-1:0]  wb2_waddr_i,
    output logic               l1_issue_o,
    output logic               l2_issue_o,
    output logic               lunch_stall_o,
    output logic [REG_NUM-1:0] pending_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] wb_clr;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] pend_eff;
    line_req_t          l1_req;
    line_req_t          l2_req;
    logic               l1_hz;
    logic               l2_hz;
    logic               pair_dep;
    logic               l1_issue;
    logic               l2_issue;
    logic               stall_inc;

    assign l1_req = '{re1: l1_re1_i, raddr1: l1_raddr1_i, re2: l1_re2_i, raddr2: l1_raddr2_i,
                      we: l1_we_i, waddr: l1_waddr_i, long_op: l1_long_i};
    assign l2_req = '{re1: l2_re1_i, raddr1: l2_raddr1_i, re2: l2_re2_i, raddr2: l2_raddr2_i,
                      we: l2_we_i, waddr: l2_waddr_i, long_op: l2_long_i};

    // Writebacks landing this cycle count as resolved since execute forwards them.
    always_comb begin
        wb_clr = '0;
        if (wb1_we_i) wb_clr[wb1_waddr_i] = 1'b1;
        if (wb2_we_i) wb_clr[wb2_waddr_i] = 1'b1;
        pend_eff = pending & ~wb_clr;
    end

    issue_hazard_chk #(.REG_NUM(REG_NUM)) u_chk_l1 (
        .req      (l1_req),
        .pend_eff (pend_eff),
        .block    (l1_hz)
    );

    issue_hazard_chk #(.REG_NUM(REG_NUM)) u_chk_l2 (
        .req      (l2_req),
        .pend_eff (pend_eff),
        .block    (l2_hz)
    );

    // Grant logic: line2 only follows line1, never across a jump, a producer in line1,
    // or a second long op in the same cycle; everything is forced low during reset.
    always_comb begin
        pair_dep = l1_we_i & (l1_waddr_i != '0) &
                   ((l2_re1_i & (l1_waddr_i == l2_raddr1_i)) |
                    (l2_re2_i & (l1_waddr_i == l2_raddr2_i)) |
                    (l2_we_i  & (l1_waddr_i == l2_waddr_i)));
        l1_issue = rst_n & next_allowin_i & ~excep_flush_i & l1_valid_i & ~l1_hz;
        l2_issue = l1_issue & l2_valid_i & ~l1_jmp_i & ~l2_hz & ~pair_dep &
                   ~(l1_long_i & l2_long_i);
        stall_inc = l1_valid_i & next_allowin_i & ~excep_flush_i & ~l1_issue;
    end

    assign l1_issue_o    = l1_issue;
    assign l2_issue_o    = l2_issue;
    assign lunch_stall_o = l1_issue & l2_valid_i & ~l2_issue & ~l1_jmp_i;
    assign pending_o     = pending;

    // New pending bits from issued long ops with a nonzero destination.
    always_comb begin
        set_vec = '0;
        if (l1_issue && l1_long_i && l1_we_i && (l1_waddr_i != '0)) set_vec[l1_waddr_i] = 1'b1;
        if (l2_issue && l2_long_i && l2_we_i && (l2_waddr_i != '0)) set_vec[l2_waddr_i] = 1'b1;
    end

    // Pending register: flush wipes everything, otherwise clear writebacks then apply sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (excep_flush_i) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_clr) | set_vec;
        end
    end

    // Count cycles where line1 could have gone but a hazard held it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_inc && rst_n) begin
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Line2 must never be valid without line1.
    l2_needs_l1 : assert property (@(posedge clk) disable iff (!rst_n) !(l2_valid_i && !l1_valid_i));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for the issue scoreboard.
module tb_issue_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        excep_flush_i;
    logic        next_allowin_i;
    logic        l1_valid_i, l1_re1_i, l1_re2_i, l1_we_i, l1_long_i, l1_jmp_i;
    logic [4:0]  l1_raddr1_i, l1_raddr2_i, l1_waddr_i;
    logic        l2_valid_i, l2_re1_i, l2_re2_i, l2_we_i, l2_long_i;
    logic [4:0]  l2_raddr1_i, l2_raddr2_i, l2_waddr_i;
    logic        wb1_we_i, wb2_we_i;
    logic [4:0]  wb1_waddr_i, wb2_waddr_i;
    logic        l1_issue_o, l2_issue_o, lunch_stall_o;
    logic [31:0] pending_o;
    logic [31:0] stall_cnt_o;

    int tests_run;
    int tests_failed;

    issue_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .excep_flush_i  (excep_flush_i),
        .next_allowin_i (next_allowin_i),
        .l1_valid_i     (l1_valid_i),
        .l1_re1_i       (l1_re1_i),
        .l1_re2_i       (l1_re2_i),
        .l1_raddr1_i    (l1_raddr1_i),
        .l1_raddr2_i    (l1_raddr2_i),
        .l1_we_i        (l1_we_i),
        .l1_waddr_i     (l1_waddr_i),
        .l1_long_i      (l1_long_i),
        .l1_jmp_i       (l1_jmp_i),
        .l2_valid_i     (l2_valid_i),
        .l2_re1_i       (l2_re1_i),
        .l2_re2_i       (l2_re2_i),
        .l2_raddr1_i    (l2_raddr1_i),
        .l2_raddr2_i    (l2_raddr2_i),
        .l2_we_i        (l2_we_i),
        .l2_waddr_i     (l2_waddr_i),
        .l2_long_i      (l2_long_i),
        .wb1_we_i       (wb1_we_i),
        .wb1_waddr_i    (wb1_waddr_i),
        .wb2_we_i       (wb2_we_i),
        .wb2_waddr_i    (wb2_waddr_i),
        .l1_issue_o     (l1_issue_o),
        .l2_issue_o     (l2_issue_o),
        .lunch_stall_o  (lunch_stall_o),
        .pending_o      (pending_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return all request inputs to idle, allowin high.
    task automatic idle();
        excep_flush_i = 0; next_allowin_i = 1; l1_jmp_i = 0;
        l1_valid_i = 0; l1_re1_i = 0; l1_re2_i = 0; l1_we_i = 0; l1_long_i = 0;
        l1_raddr1_i = 0; l1_raddr2_i = 0; l1_waddr_i = 0;
        l2_valid_i = 0; l2_re1_i = 0; l2_re2_i = 0; l2_we_i = 0; l2_long_i = 0;
        l2_raddr1_i = 0; l2_raddr2_i = 0; l2_waddr_i = 0;
        wb1_we_i = 0; wb1_waddr_i = 0; wb2_we_i = 0; wb2_waddr_i = 0;
    endtask

    task automatic set_l1(input logic re1, input logic [4:0] ra1, input logic we,
                          input logic [4:0] wa, input logic lng);
        l1_valid_i = 1; l1_re1_i = re1; l1_raddr1_i = ra1; l1_re2_i = 0; l1_raddr2_i = 0;
        l1_we_i = we; l1_waddr_i = wa; l1_long_i = lng;
    endtask

    task automatic set_l2(input logic re1, input logic [4:0] ra1, input logic we,
                          input logic [4:0] wa, input logic lng);
        l2_valid_i = 1; l2_re1_i = re1; l2_raddr1_i = ra1; l2_re2_i = 0; l2_raddr2_i = 0;
        l2_we_i = we; l2_waddr_i = wa; l2_long_i = lng;
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        set_l1(0, 0, 1, 5, 1);
        #2;
        tests_run++;
        if (l1_issue_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_issue: got %b want 0", l1_issue_o);
        end
        tests_run++;
        if (pending_o !== 32'h0 || stall_cnt_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: pending %h cnt %0d want 0 0", pending_o, stall_cnt_o);
        end
        idle();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_dual_issue();
        set_l1(0, 0, 1, 5, 1);
        set_l2(1, 7, 1, 6, 0);
        #1;
        tests_run++;
        if ({l1_issue_o, l2_issue_o, lunch_stall_o} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL dual_issue: got %b want 110", {l1_issue_o, l2_issue_o, lunch_stall_o});
        end
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0000_0020) begin
            tests_failed++;
            $display("[TB] FAIL load_sets_pending: got %h want 00000020", pending_o);
        end
    endtask

    task automatic test_raw_stall();
        set_l1(1, 5, 1, 8, 0);
        #1;
        tests_run++;
        if (l1_issue_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL raw_block: got %b want 0", l1_issue_o);
        end
        tick();
        tick();
        tests_run++;
        if (stall_cnt_o !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL stall_count: got %0d want 2", stall_cnt_o);
        end
        wb1_we_i = 1; wb1_waddr_i = 5;
        #1;
        tests_run++;
        if (l1_issue_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wb_same_cycle_issue: got %b want 1", l1_issue_o);
        end
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0 || stall_cnt_o !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL wb_clear: pending %h cnt %0d want 0 2", pending_o, stall_cnt_o);
        end
    endtask

    task automatic test_pair_dep();
        set_l1(1, 1, 1, 3, 0);
        set_l2(1, 3, 1, 4, 0);
        #1;
        tests_run++;
        if ({l1_issue_o, l2_issue_o, lunch_stall_o} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL pair_dep: got %b want 101", {l1_issue_o, l2_issue_o, lunch_stall_o});
        end
        tick();
        idle();
        set_l1(1, 3, 1, 4, 0);
        #1;
        tests_run++;
        if ({l1_issue_o, l2_issue_o, lunch_stall_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL held_line_issues: got %b want 100", {l1_issue_o, l2_issue_o, lunch_stall_o});
        end
        tick();
        idle();
    endtask

    task automatic test_jmp_long();
        set_l1(0, 0, 0, 0, 0);
        l1_jmp_i = 1;
        set_l2(1, 2, 1, 6, 0);
        #1;
        tests_run++;
        if ({l1_issue_o, l2_issue_o, lunch_stall_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL jmp_pair: got %b want 100", {l1_issue_o, l2_issue_o, lunch_stall_o});
        end
        idle();
        set_l1(0, 0, 1, 4, 1);
        set_l2(0, 0, 1, 9, 1);
        #1;
        tests_run++;
        if ({l1_issue_o, l2_issue_o, lunch_stall_o} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL two_long: got %b want 101", {l1_issue_o, l2_issue_o, lunch_stall_o});
        end
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0000_0010) begin
            tests_failed++;
            $display("[TB] FAIL div_pending: got %h want 00000010", pending_o);
        end
        wb2_we_i = 1; wb2_waddr_i = 4;
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL wb2_clear: got %h want 0", pending_o);
        end
    endtask

    task automatic test_flush();
        set_l1(0, 0, 1, 5, 1);
        tick();
        idle();
        set_l1(0, 0, 1, 9, 1);
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0000_0220) begin
            tests_failed++;
            $display("[TB] FAIL two_pending: got %h want 00000220", pending_o);
        end
        excep_flush_i = 1;
        set_l1(0, 0, 1, 10, 1);
        #1;
        tests_run++;
        if (l1_issue_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_no_issue: got %b want 0", l1_issue_o);
        end
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0 || stall_cnt_o !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL flush_state: pending %h cnt %0d want 0 2", pending_o, stall_cnt_o);
        end
        wb1_we_i = 1; wb1_waddr_i = 5;
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL stale_wb: got %h want 0", pending_o);
        end
        next_allowin_i = 0;
        set_l1(0, 0, 1, 11, 1);
        #1;
        tests_run++;
        if (l1_issue_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL allowin_low_issue: got %b want 0", l1_issue_o);
        end
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0 || stall_cnt_o !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL allowin_low_state: pending %h cnt %0d want 0 2", pending_o, stall_cnt_o);
        end
    endtask

    task automatic test_edges();
        set_l1(0, 0, 1, 12, 1);
        tick();
        idle();
        wb1_we_i = 1; wb1_waddr_i = 12;
        set_l1(0, 0, 1, 12, 1);
        #1;
        tests_run++;
        if (l1_issue_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL waw_resolved_by_wb: got %b want 1", l1_issue_o);
        end
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0000_1000) begin
            tests_failed++;
            $display("[TB] FAIL set_wins: got %h want 00001000", pending_o);
        end
        wb2_we_i = 1; wb2_waddr_i = 12;
        tick();
        idle();
        set_l1(0, 0, 1, 0, 1);
        tick();
        idle();
        tests_run++;
        if (pending_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL r0_never_pending: got %h want 0", pending_o);
        end
        set_l1(0, 0, 1, 7, 1);
        tick();
        set_l1(1, 7, 1, 8, 0);
        tick();
        tests_run++;
        if (pending_o !== 32'h0000_0080 || stall_cnt_o !== 32'd3) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset: pending %h cnt %0d want 00000080 3", pending_o, stall_cnt_o);
        end
        #2;
        rst_n = 0;
        #1;
        tests_run++;
        if (pending_o !== 32'h0 || stall_cnt_o !== 32'h0 || l1_issue_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: pending %h cnt %0d issue %b want 0 0 0",
                     pending_o, stall_cnt_o, l1_issue_o);
        end
        idle();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle();
        rst_n = 0;
        #1;
        test_reset();
        test_dual_issue();
        test_raw_stall();
        test_pair_dep();
        test_jmp_long();
        test_flush();
        test_edges();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
